// File: rtl/microseq.sv
// microseq: micro-sequencer ahead of the instruction decoder.
// Holds the instruction register, the T-state counter and a retired-instruction
// counter. Define MICROSEQ_STEP_EN to add single-step support (step/step_mode
// inputs). Without it, step_wait is tied to 0.
module microseq #(
  parameter int          T_MAX    = 7,
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  input  logic        ir_load,
  input  logic        t_reset,
  input  logic        stall,
`ifdef MICROSEQ_STEP_EN
  input  logic        step,
  input  logic        step_mode,
`endif
  output logic [15:0] instr,
  output logic [2:0]  T,
  output logic        fetch,
  output logic [15:0] retired,
  output logic        step_wait
);

  // The T counter is only 3 bits wide, so T_MAX must fit it and leave room
  // for at least a fetch phase plus one execute state.
  generate
    if (T_MAX < 2 || T_MAX > 7) begin : g_bad_tmax
      $error("microseq: T_MAX must be in 2..7");
    end
  endgenerate

  localparam logic [2:0] TMAX3 = 3'(T_MAX);

  logic end_instr;
  logic hold;

  // The instruction ends either on request from microcode or by running out of T-states.
  assign end_instr = t_reset || (T == TMAX3);

  // T=0 and T=1 are the fetch microcode phase.
  assign fetch = (T == 3'd0) || (T == 3'd1);

`ifdef MICROSEQ_STEP_EN
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } step_state_t;

  step_state_t state, state_nxt;

  // Single-step state register; reset always returns to free-running.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Enter WAIT as an instruction completes in step mode; leave on step or step_mode drop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (!stall && end_instr && step_mode)  state_nxt = ST_WAIT;
      ST_WAIT: if (!stall && (step || !step_mode))    state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign step_wait = (state == ST_WAIT);
`else
  assign step_wait = 1'b0;
`endif

  // A single-step hold freezes the sequencer exactly like a memory stall. The
  // edge that releases WAIT still holds, so sequencing restarts cleanly from T=0.
  assign hold = stall || step_wait;

  // IR, T-state and retired counter; requests arriving during a hold are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= IR_RESET;
      T       <= 3'd0;
      retired <= 16'd0;
    end else if (!hold) begin
      if (ir_load) instr <= bus_in;
      if (end_instr) begin
        T       <= 3'd0;
        retired <= retired + 16'd1;
      end else begin
        T       <= T + 3'd1;
      end
    end
  end

endmodule

// File: doc/microseq.md
Name: microseq

Overview:
- Micro-sequencer sitting directly upstream of the instruction decoder.
- Holds the instruction register and the 3-bit T-state counter. Both drive the decoder's instr/T inputs.
- Consumes the T-reset and IR-load control bits that come back from the decoded microinstruction. Bus is 16-bit.
- Also maintains a retired-instruction counter for debug/trace.

Parameters:
- T_MAX, 7, highest T-state. Counter wraps to 0 after T_MAX. Legal 2..7.
- IR_RESET, 16'h0000, IR value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- bus_in  in  16  CPU data bus, source for IR load
- ir_load  in  1  microinstruction IR-load bit; latch bus_in into IR this edge
- t_reset  in  1  microinstruction end-of-instruction bit; next T is 0
- stall  in  1  memory/IO wait; freeze T, IR and counters
- instr  out  16  instruction register, to decoder
- T  out  3  current T-state, to decoder
- fetch  out  1  combinational, 1 when T is 0 or 1 (fetch microcode phase)
- retired  out  16  count of completed instructions, wraps mod 2^16
- step_wait  out  1  single-step hold indicator (0 when feature compiled out)

Behaviour:
- Reset values (synchronous, active-high, priority over everything):
  - instr=IR_RESET
  - T=0
  - retired=0
  - step_wait=0
- Reset asserted mid-instruction: next edge forces the reset state regardless of stall/ir_load/t_reset.
- Per edge, not reset, stall=0:
  - IR: if ir_load, then instr <= bus_in; else instr holds.
  - T: if t_reset, or T==T_MAX, then T <= 0 and retired <= retired+1; else T <= T+1.
- stall=1: T, instr, retired all hold. stall overrides ir_load and t_reset, and those requests are dropped. Control logic must hold them asserted until stall clears.
- Simultaneous ir_load and t_reset: both take effect. IR gets bus_in, T goes to 0, retired increments.
- t_reset at T=0: T stays 0 and retired increments. This is a degenerate one-cycle instruction, and it is legal.
- Wrap: retired 16'hFFFF+1 -> 16'h0000, no flag. T at T_MAX without t_reset -> 0, counted as retired.
- Latency:
  - instr/T visible to the decoder one cycle after the edge that updates them.
  - fetch follows T combinationally.
- T is never > T_MAX. Behaviour for T_MAX outside 2..7 is undefined (elaboration check recommended).

Optional Feature:
- Macro: MICROSEQ_STEP_EN. Adds input step (1 bit, single-cycle strobe) and input step_mode (1 bit).
- With the macro:
  - When step_mode=1 and T is about to return to 0, T enters 0 and then sets step_wait=1.
  - While step_wait=1, T, IR and retired hold, as if stall.
  - A step strobe clears step_wait on the next edge, and sequencing resumes from T=0.
  - step_mode=0 clears step_wait on the next edge.
  - stall has priority over step.
  - Reset clears step_wait.
- Without the macro: no step/step_mode ports; step_wait tied 0; behaviour exactly as above.

Test Plan:
- Reset then free-run, ir_load=0, t_reset=0:
  - T sequence 0,1,2,3,4,5,6,7,0 on successive edges.
  - retired 0->1 on the wrap edge.
  - instr stays 16'h0000.
  - fetch=1 only at T=0,1.
- Load and short instruction:
  - bus_in=16'h0300, ir_load=1 at T=1 -> instr=16'h0300 at T=2.
  - t_reset=1 at T=2 -> next T=0, retired increments by 1.
  - Decoder sees (instr=0x0300, T=2) for exactly one cycle.
- Stall:
  - At T=3, stall=1 for 4 cycles with ir_load=1, bus_in=16'h6400 -> T stays 3, instr unchanged, retired unchanged.
  - After release -> T=4.
- Simultaneous ir_load+t_reset at T=5, bus_in=16'hABCD -> next edge: instr=16'hABCD, T=0, retired+1.
- Reset mid-op: at T=4 with instr=16'h1234, retired=5, assert reset for one edge -> instr=0, T=0, retired=0, ignoring concurrent ir_load/t_reset/stall.
- With MICROSEQ_STEP_EN:
  - step_mode=1 -> after the first instruction ends, step_wait=1 and T holds 0 for 10 cycles.
  - Pulse step -> step_wait=0 next edge, T advances 0->1.
  - Wrap check: preload 65535 retirements (or force) -> retired reads 16'h0000 after next completion.
